// File: rtl/uart_rx.sv
// UART receiver: oversampled 8N1-style frame recovery with a valid/ready byte output.
// Optional parity bit checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx #(
    parameter int DATA_BITS    = 8,
    parameter int OVERSAMPLING = 8
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit ODD_PARITY   = 1'b0
`endif
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 sample_tick,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 busy,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_error,
`endif
    output logic [2:0]           dbg_state
);

    localparam int TC_W = $clog2(OVERSAMPLING);
    localparam int BC_W = $clog2(DATA_BITS + 1);
    localparam logic [TC_W-1:0] TC_MID  = TC_W'(OVERSAMPLING / 2 - 1);
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(OVERSAMPLING - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Handshake: a byte is transferred on every clock where rx_valid && rx_ready.
    // rx_valid stays high until that transfer; rx_ready is don't-care while rx_valid is low.
    state_t                 r_state;
    logic                   r_sync1;
    logic                   r_rxs;
    logic [TC_W-1:0]        r_tc;
    logic [BC_W-1:0]        r_bc;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_rx_data;
    logic                   r_rx_valid;
    logic                   r_frame_error;
    logic                   r_overrun;

    state_t                 w_state_next;
    logic [TC_W-1:0]        w_tc_next;
    logic [BC_W-1:0]        w_bc_next;
    logic [DATA_BITS-1:0]   w_shift_next;
    logic                   w_stop_sample;
    logic                   w_par_bad;
    logic                   w_good;
    logic                   w_load;

`ifdef UART_RX_PARITY_EN
    logic                   r_par_bit;
    logic                   w_par_bit_next;
    logic                   r_parity_error;
`endif

    always_comb begin
        w_state_next  = r_state;
        w_tc_next     = r_tc;
        w_bc_next     = r_bc;
        w_shift_next  = r_shift;
        w_stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bit_next = r_par_bit;
`endif
        if (sample_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rxs) begin
                        w_state_next = S_START;
                        w_tc_next    = '0;
                    end
                end
                S_START: begin
                    if (r_tc == TC_MID) begin
                        w_tc_next    = '0;
                        w_bc_next    = '0;
                        w_state_next = r_rxs ? S_IDLE : S_DATA;
                    end else begin
                        w_tc_next = r_tc + TC_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_tc == TC_LAST) begin
                        // Shifting in from the top leaves the first (LSB) bit at index 0.
                        w_tc_next    = '0;
                        w_shift_next = {r_rxs, r_shift[DATA_BITS-1:1]};
                        w_bc_next    = r_bc + BC_W'(1);
                        if (r_bc == BC_LAST) begin
`ifdef UART_RX_PARITY_EN
                            w_state_next = S_PARITY;
`else
                            w_state_next = S_STOP;
`endif
                        end
                    end else begin
                        w_tc_next = r_tc + TC_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_tc == TC_LAST) begin
                        w_tc_next      = '0;
                        w_par_bit_next = r_rxs;
                        w_state_next   = S_STOP;
                    end else begin
                        w_tc_next = r_tc + TC_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    // Leave at mid stop bit so an immediately following start edge is caught.
                    if (r_tc == TC_LAST) begin
                        w_tc_next     = '0;
                        w_stop_sample = 1'b1;
                        w_state_next  = S_IDLE;
                    end else begin
                        w_tc_next = r_tc + TC_W'(1);
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    assign w_par_bad = ((^r_shift) ^ r_par_bit) != ODD_PARITY;
`else
    assign w_par_bad = 1'b0;
`endif
    assign w_good = w_stop_sample && r_rxs && !w_par_bad;
    assign w_load = w_good && (!r_rx_valid || rx_ready);

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_state       <= S_IDLE;
            r_sync1       <= 1'b1;
            r_rxs         <= 1'b1;
            r_tc          <= '0;
            r_bc          <= '0;
            r_shift       <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit      <= 1'b0;
            r_parity_error <= 1'b0;
`endif
        end else begin
            r_sync1       <= rx;
            r_rxs         <= r_sync1;
            r_state       <= w_state_next;
            r_tc          <= w_tc_next;
            r_bc          <= w_bc_next;
            r_shift       <= w_shift_next;
            r_frame_error <= w_stop_sample && !r_rxs;
            r_overrun     <= w_good && r_rx_valid && !rx_ready;
            if (w_load) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (rx_ready) begin
                r_rx_valid <= 1'b0;
            end
`ifdef UART_RX_PARITY_EN
            r_par_bit      <= w_par_bit_next;
            r_parity_error <= w_stop_sample && r_rxs && w_par_bad;
`endif
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;
    assign busy        = (r_state != S_IDLE);
    assign dbg_state   = r_state;
`ifdef UART_RX_PARITY_EN
    assign parity_error = r_parity_error;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver. Recovers 8N1-style serial frames from the line `rx` using an oversampling tick produced by the baud rate generator.
- Presents each received byte on a valid/ready handshake to the host logic.
- Sits beside the UART transmitter. Runs entirely in the system clock domain and uses `sample_tick` as a clock enable.

Parameters:
- DATA_BITS, 8, payload bits per frame, LSB first, range 5..9.
- OVERSAMPLING, 8, `sample_tick` pulses per bit period. Must be even and >= 4.

Ports:
- clock  input  1  system clock, rising edge.
- nreset  input  1  synchronous active-low reset.
- sample_tick  input  1  one-clock pulse at BAUDRATE*OVERSAMPLING rate.
- rx  input  1  asynchronous serial line, idle high.
- rx_ready  input  1  host accepts `rx_data` when high together with `rx_valid`.
- rx_data  output  DATA_BITS  received payload.
- rx_valid  output  1  `rx_data` holds an unconsumed byte.
- frame_error  output  1  one-clock pulse: stop bit sampled low.
- overrun  output  1  one-clock pulse: frame completed while `rx_valid` was still pending.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (`nreset` low at a clock edge):
  - FSM goes to IDLE.
  - Outputs: `rx_data`=0, `rx_valid`=0, `frame_error`=0, `overrun`=0, `busy`=0.
  - Sync flops and counters: sync flops = 1, tick counter = 0, bit counter = 0.
  - Reset mid-frame discards the partial frame.
- `rx` passes through a 2-flop synchronizer. All decisions use the synchronized value `rxs`. Sync flops update every clock, not only on ticks.
- Tick counter `tc` (width clog2(OVERSAMPLING)) and bit counter `bc` advance only on `sample_tick`.
- IDLE:
  - On a tick with `rxs`=0: go to START, `tc`=0.
- START:
  - On each tick `tc`++.
  - On the tick where `tc`==OVERSAMPLING/2-1 (mid start bit):
    - `rxs`=0: go to DATA, `tc`=0, `bc`=0.
    - `rxs`=1: glitch; return to IDLE with no outputs.
- DATA:
  - On each tick `tc`++, wrapping at OVERSAMPLING-1.
  - On the tick where `tc`==OVERSAMPLING-1: shift `rxs` into shift register bit `bc` (LSB first), `bc`++.
  - After DATA_BITS samples: go to PARITY if the feature is compiled in, else STOP.
- STOP:
  - Sample at `tc`==OVERSAMPLING-1 (mid stop bit).
  - `rxs`=1, good frame:
    - If `rx_valid`=0, or `rx_ready`=1 in that cycle: `rx_data` ← shift register and `rx_valid`=1 from the next cycle.
    - Else: `overrun` pulses next cycle, `rx_data` is unchanged, the new byte is dropped.
  - `rxs`=0: `frame_error` pulses next cycle and the byte is discarded.
  - Either way, return to IDLE at the stop sample (mid-bit), so a following start bit is detected without losing a bit.
- Handshake:
  - `rx_valid` clears on the clock after a cycle with `rx_valid` && `rx_ready`, unless a new byte is loaded in that same cycle. In that case `rx_valid` stays 1 and `rx_data` holds the new byte.
  - `rx_ready` is ignored while `rx_valid`=0.
- Latency: line start edge to `rx_valid` high is (1+DATA_BITS+0.5) bit periods + 2 sync clocks + up to 1 tick + 1 clock.
- `sample_tick` held low: FSM freezes in its current state with no timeouts.
- `sample_tick` asserted on consecutive clocks is legal; each clock counts as one tick.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Adds parameter ODD_PARITY (default 0) and output `parity_error` (1-clock pulse).
  - Adds a PARITY state after DATA, sampled like a data bit.
  - Parity mismatch: `parity_error` pulses at the same cycle the frame would deliver, and the byte is discarded.
  - A stop-bit error takes precedence: only `frame_error` pulses.
- When undefined: no PARITY state and no `parity_error` port. Frame is start + DATA_BITS + stop.

Test Plan:
- Basic receive: defaults, `sample_tick` every 4 clocks, send 0xA5 with 1 stop bit, `rx_ready`=0 → `rx_valid`=1, `rx_data`=0xA5, `frame_error`=0, `busy`=0 afterwards.
- Start glitch rejection: `rx` low for 3 clocks (< half bit) then high → FSM back in IDLE, no `rx_valid`, no error pulse.
- Framing error: send 0x3C with the stop bit driven 0 → `frame_error` pulses for exactly 1 clock, `rx_valid` stays 0.
- Overrun and handshake: send 0x11, hold `rx_ready`=0, send 0x22 → `overrun` pulses 1 clock, `rx_data` stays 0x11. Then `rx_ready`=1 for 1 clock → `rx_valid`=0.
- Back-to-back frames: 0x00 then 0xFF with no idle gap, `rx_ready` tied high → two `rx_valid` pulses carrying 0x00 then 0xFF, no errors.
- Reset mid-frame, and parity: pull `nreset` low during bit 4 of 0x55 → all outputs 0, and the next frame 0x81 is received correctly. With UART_RX_PARITY_EN and even parity, 0x07 sent with parity bit 0 → `parity_error` pulse, no `rx_valid`.
